gf_mult_serial: RTL and testbench
=================================

GF_MULT_SERIAL -- requirements
Module: gf_mult_serial

Interface
REQ-001 Parameter NB_DATA, default 8, field width n for GF(2^n) operands and result.
REQ-002 Parameter POLY, default 8'h1b, low n bits of the reduction polynomial; the x^n term is implicit.
REQ-003 Parameter NB_STEP, default 1, multiplier bits processed per clock.
REQ-004 i_clock  input  1  single clock; all state updates on its rising edge.
REQ-005 i_reset_n  input  1  reset, asynchronous, active-low.
REQ-006 i_flush  input  1  synchronous abort of any operation in progress.
REQ-007 i_valid  input  1  operand pair on i_data_a/i_data_b is valid.
REQ-008 i_data_a  input  NB_DATA  multiplicand.
REQ-009 i_data_b  input  NB_DATA  multiplier, consumed MSB first.
REQ-010 o_ready  output  1  block can accept an operand pair.
REQ-011 o_data  output  NB_DATA  product a*b mod POLY.
REQ-012 o_valid  output  1  o_data holds a completed product.
REQ-013 i_ready  input  1  consumer accepts o_data.

Function
REQ-014 Configuration SHALL fail elaboration when NB_DATA < 2, or NB_STEP < 1, or NB_DATA % NB_STEP != 0.
REQ-015 States SHALL be IDLE, CALC, DONE; o_ready SHALL equal (state == IDLE).
REQ-016 Accept SHALL occur on an edge with i_valid && o_ready && !i_flush: latch a into reg_a, b into reg_b, clear accumulator, zero step counter, go to CALC.
REQ-017 Each CALC edge SHALL do NB_STEP Horner steps: acc = xtime_n(acc) ^ (b_msb ? reg_a : 0); reg_b shifts left one per step.
REQ-018 xtime_n(x) SHALL be {x[n-2:0],0} when x[n-1]==0, else {x[n-2:0],0} ^ POLY.
REQ-019 Step counter SHALL run 0 .. NB_DATA/NB_STEP-1; the edge processing the last count SHALL enter DONE.
REQ-020 Latency: o_valid SHALL rise exactly NB_DATA/NB_STEP cycles after the accept edge (8 for defaults).
REQ-021 In DONE, o_valid=1 and o_data=acc SHALL be held stable until an edge with i_ready=1; that edge SHALL go to IDLE.
REQ-022 Outside DONE, o_valid SHALL be 0; o_data SHALL keep its last value.
REQ-023 The block SHALL NOT accept a new pair in the same cycle a result is consumed; minimum issue interval is NB_DATA/NB_STEP+2 cycles.
REQ-024 i_valid while o_ready=0 SHALL be ignored; no operand is queued.
REQ-025 i_flush=1 SHALL force IDLE on the next edge from any state, clear acc, counter and o_valid, and take priority over accept and over output handshake.
REQ-026 Operand 0 in either input SHALL yield 0; operand 1 SHALL yield the other operand unchanged.

Reset
REQ-027 While i_reset_n=0: state=IDLE, acc=0, reg_a=0, reg_b=0, counter=0, o_data=0, o_valid=0, o_ready=1; inputs ignored.
REQ-028 Reset asserted mid-CALC or in DONE SHALL abort immediately (asynchronous); the partial result SHALL never appear on o_valid.
REQ-029 The first accept SHALL be possible on the first rising edge after i_reset_n deasserts.

Verification
REQ-030 Defaults, a=0x57, b=0x83, i_ready=1 -> o_valid high 8 cycles after accept, o_data=0xc1, then o_ready=1 one cycle later.
REQ-031 Defaults, a=0x57, b=0x02 -> 0xae; a=0x57, b=0x13 -> 0xfe; a=0x00, b=0xff -> 0x00; a=0x01, b=0xa5 -> 0xa5.
REQ-032 NB_STEP=4, a=0x57, b=0x83 -> o_data=0xc1 two cycles after accept.
REQ-033 Backpressure: i_ready=0 for 5 cycles in DONE -> o_valid and o_data=0xc1 stable; i_valid pulses ignored; release -> one transfer, then IDLE.
REQ-034 i_flush at CALC count 3, then accept a=0x02, b=0x80 -> no o_valid for the flushed op; second result 0x1b.
REQ-035 i_reset_n low at CALC count 5 -> o_valid=0, o_data=0, o_ready=1 during reset; a fresh op after release yields the correct product.

Source files
------------

// File: rtl/gf_mult_serial.sv
// Bit-serial GF(2^n) multiplier: Horner evaluation of the multiplier MSB first,
// NB_STEP bits per clock, with a valid/ready result handshake.
module gf_mult_serial #(
    parameter int unsigned        NB_DATA = 8,
    parameter logic [NB_DATA-1:0] POLY    = 8'h1b,
    parameter int unsigned        NB_STEP = 1
) (
    input  logic               i_clock,
    input  logic               i_reset_n,
    input  logic               i_flush,
    input  logic               i_valid,
    input  logic [NB_DATA-1:0] i_data_a,
    input  logic [NB_DATA-1:0] i_data_b,
    output logic               o_ready,
    output logic [NB_DATA-1:0] o_data,
    output logic               o_valid,
    input  logic               i_ready
);

    localparam int unsigned STEP_SAFE = (NB_STEP == 0) ? 1 : NB_STEP;
    localparam int unsigned NSTEPS    = NB_DATA / STEP_SAFE;
    localparam int unsigned CW        = (NSTEPS > 1) ? $clog2(NSTEPS) : 1;
    localparam logic [CW-1:0] LAST    = CW'(NSTEPS - 1);

    generate
        if (NB_DATA < 2 || NB_STEP < 1 || (NB_DATA % STEP_SAFE) != 0) begin : g_bad_cfg
            $error("gf_mult_serial: illegal NB_DATA/NB_STEP combination");
        end
    endgenerate

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t              state;
    logic [NB_DATA-1:0]  reg_a;
    logic [NB_DATA-1:0]  reg_b;
    logic [NB_DATA-1:0]  acc;
    logic [CW-1:0]       count;
    logic [NB_DATA-1:0]  acc_step;
    logic [NB_DATA-1:0]  b_step;

    function automatic logic [NB_DATA-1:0] xtime(input logic [NB_DATA-1:0] x);
        logic [NB_DATA-1:0] sh;
        sh = {x[NB_DATA-2:0], 1'b0};
        return x[NB_DATA-1] ? (sh ^ POLY) : sh;
    endfunction

    // NB_STEP chained Horner steps evaluated within one clock
    always_comb begin
        acc_step = acc;
        b_step   = reg_b;
        for (int unsigned i = 0; i < NB_STEP; i++) begin
            acc_step = xtime(acc_step) ^ (b_step[NB_DATA-1] ? reg_a : '0);
            b_step   = {b_step[NB_DATA-2:0], 1'b0};
        end
    end

    assign o_ready = (state == IDLE);

    always_ff @(posedge i_clock or negedge i_reset_n) begin
        if (!i_reset_n) begin
            state   <= IDLE;
            reg_a   <= '0;
            reg_b   <= '0;
            acc     <= '0;
            count   <= '0;
            o_data  <= '0;
            o_valid <= 1'b0;
        end else if (i_flush) begin
            state   <= IDLE;
            acc     <= '0;
            count   <= '0;
            o_valid <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (i_valid) begin
                        reg_a <= i_data_a;
                        reg_b <= i_data_b;
                        acc   <= '0;
                        count <= '0;
                        state <= CALC;
                    end
                end
                CALC: begin
                    acc   <= acc_step;
                    reg_b <= b_step;
                    if (count == LAST) begin
                        state   <= DONE;
                        o_valid <= 1'b1;
                        o_data  <= acc_step;
                    end else begin
                        count <= count + 1'b1;
                    end
                end
                DONE: begin
                    if (i_ready) begin
                        state   <= IDLE;
                        o_valid <= 1'b0;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_gf_mult_serial.sv
// Randomized and directed checks of gf_mult_serial against a carry-less
// multiply-then-reduce reference model.
module tb_gf_mult_serial;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       flush, valid, rdy;
    logic [7:0] data_a, data_b;
    logic       o_ready, o_valid;
    logic [7:0] o_data;

    logic       valid4, rdy4, flush4;
    logic [7:0] data_a4, data_b4;
    logic       o_ready4, o_valid4;
    logic [7:0] o_data4;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    gf_mult_serial dut (
        .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush), .i_valid(valid),
        .i_data_a(data_a), .i_data_b(data_b), .o_ready(o_ready),
        .o_data(o_data), .o_valid(o_valid), .i_ready(rdy)
    );

    gf_mult_serial #(.NB_DATA(8), .POLY(8'h1b), .NB_STEP(4)) dut4 (
        .i_clock(clk), .i_reset_n(rst_n), .i_flush(flush4), .i_valid(valid4),
        .i_data_a(data_a4), .i_data_b(data_b4), .o_ready(o_ready4),
        .o_data(o_data4), .o_valid(o_valid4), .i_ready(rdy4)
    );

    // Polynomial product of degree <= 14, then long division by x^8+x^4+x^3+x+1
    function automatic logic [7:0] gf_ref(input logic [7:0] a, input logic [7:0] b);
        logic [15:0] p;
        p = '0;
        for (int i = 0; i < 8; i++)
            if (b[i]) p = p ^ (16'(a) << i);
        for (int i = 14; i >= 8; i--)
            if (p[i]) p = p ^ (16'h011b << (i - 8));
        return p[7:0];
    endfunction

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    // Called at #1 after an edge with the default instance idle and rdy=1
    task automatic run_op(input string tag, input logic [7:0] a, input logic [7:0] b);
        int cyc;
        check({tag, "_ready"}, 32'(o_ready), 1);
        data_a = a; data_b = b; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        cyc = 0;
        while (!o_valid && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 8);
        check({tag, "_data"}, 32'(o_data), 32'(gf_ref(a, b)));
        @(posedge clk); #1;
        check({tag, "_valid_drop"}, 32'(o_valid), 0);
        check({tag, "_ready_back"}, 32'(o_ready), 1);
    endtask

    task automatic run_op4(input string tag, input logic [7:0] a, input logic [7:0] b);
        int cyc;
        data_a4 = a; data_b4 = b; valid4 = 1'b1;
        @(posedge clk); #1;
        valid4 = 1'b0;
        cyc = 0;
        while (!o_valid4 && cyc < 20) begin
            @(posedge clk); #1;
            cyc++;
        end
        check({tag, "_latency"}, 32'(cyc), 2);
        check({tag, "_data"}, 32'(o_data4), 32'(gf_ref(a, b)));
        @(posedge clk); #1;
        check({tag, "_ready_back"}, 32'(o_ready4), 1);
    endtask

    initial begin
        rst_n = 1'b0; flush = 1'b0; valid = 1'b0; rdy = 1'b1;
        data_a = '0; data_b = '0;
        valid4 = 1'b0; rdy4 = 1'b1; flush4 = 1'b0; data_a4 = '0; data_b4 = '0;
        #2;
        check("rst_ready", 32'(o_ready), 1);
        check("rst_valid", 32'(o_valid), 0);
        check("rst_data", 32'(o_data), 0);
        @(posedge clk); #1;
        @(posedge clk); #1;
        rst_n = 1'b1;

        run_op("v_57_83", 8'h57, 8'h83);
        check("v_57_83_const", 32'(gf_ref(8'h57, 8'h83)), 32'h0c1);
        run_op("v_57_02", 8'h57, 8'h02);
        run_op("v_57_13", 8'h57, 8'h13);
        run_op("v_00_ff", 8'h00, 8'hff);
        run_op("v_01_a5", 8'h01, 8'ha5);
        run_op("v_ff_00", 8'hff, 8'h00);
        run_op("v_c3_01", 8'hc3, 8'h01);
        run_op("v_ff_ff", 8'hff, 8'hff);

        for (int i = 0; i < 20; i++)
            run_op("rand", 8'($urandom), 8'($urandom));

        run_op4("s4_57_83", 8'h57, 8'h83);
        for (int i = 0; i < 6; i++)
            run_op4("s4_rand", 8'($urandom), 8'($urandom));

        // Backpressure: result held while rdy=0, stray valid pulses ignored
        rdy = 1'b0;
        data_a = 8'h57; data_b = 8'h83; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        for (int i = 0; i < 20 && !o_valid; i++) begin
            @(posedge clk); #1;
        end
        check("bp_valid_rise", 32'(o_valid), 1);
        for (int i = 0; i < 5; i++) begin
            valid = i[0]; data_a = 8'h11; data_b = 8'h22;
            @(posedge clk); #1;
            check("bp_hold_valid", 32'(o_valid), 1);
            check("bp_hold_data", 32'(o_data), 32'h0c1);
            check("bp_hold_ready", 32'(o_ready), 0);
        end
        valid = 1'b0;
        rdy = 1'b1;
        @(posedge clk); #1;
        check("bp_release_valid", 32'(o_valid), 0);
        check("bp_release_ready", 32'(o_ready), 1);
        @(posedge clk); #1;
        check("bp_no_queued_op", 32'(o_ready), 1);

        // Flush at CALC count 3 with a new request offered simultaneously
        data_a = 8'h57; data_b = 8'h83; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (3) begin @(posedge clk); #1; end
        flush = 1'b1; valid = 1'b1;
        @(posedge clk); #1;
        check("fl_ready", 32'(o_ready), 1);
        @(posedge clk); #1;
        check("fl_priority_over_accept", 32'(o_ready), 1);
        flush = 1'b0; valid = 1'b0;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("fl_no_valid", 32'(o_valid), 0);
        end
        run_op("fl_second", 8'h02, 8'h80);
        check("fl_second_const", 32'(o_data), 32'h01b);

        // Asynchronous reset at CALC count 5
        data_a = 8'h57; data_b = 8'h83; valid = 1'b1;
        @(posedge clk); #1;
        valid = 1'b0;
        repeat (5) begin @(posedge clk); #1; end
        rst_n = 1'b0;
        #1;
        check("ar_valid", 32'(o_valid), 0);
        check("ar_data", 32'(o_data), 0);
        check("ar_ready", 32'(o_ready), 1);
        valid = 1'b1;
        @(posedge clk); #1;
        check("ar_inputs_ignored", 32'(o_ready), 1);
        valid = 1'b0;
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) begin
            @(posedge clk); #1;
            check("ar_no_partial", 32'(o_valid), 0);
        end
        run_op("ar_fresh", 8'h57, 8'h13);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
